// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: a Moore FSM that sequences fetch, decode and
// the per-class execute/writeback steps, plus a sticky illegal-opcode flag.
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // State register and sticky illegal flag; reset overrides any transition.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; Op is only looked at in DECODE and MEMADR.
    always_comb begin
        // NOTE: defaults first so no branch can leave a variable unassigned (latch).
        state_d   = FETCH;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;  // writeback/terminal states and unused codes
        endcase
    end

    // Moore output decode from the current state only.
    always_comb begin
        ALUOp    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;  // unused encodings drive all zeros
        endcase
    end

    assign PCEn      = PCWrite | (Branch & Zero);
    assign IllegalOp = illegal_q;
    assign State     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for the multicycle controller: each instruction's expected
// state walk comes from a per-class sequence table, outputs from a per-state table.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, PCWrite, Branch;
    logic       PCEn, IllegalOp;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;
    logic exp_illegal;

    typedef int seq_t[$];

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCWrite(PCWrite), .Branch(Branch),
        .PCEn(PCEn), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // State walk of one instruction, from FETCH up to (not including) the next FETCH.
    function automatic seq_t seq_for(input logic [5:0] op);
        case (op)
            6'b100011: return '{0, 1, 2, 3, 4};  // lw
            6'b101011: return '{0, 1, 2, 5};     // sw
            6'b000000: return '{0, 1, 6, 7};     // R-type
            6'b001000: return '{0, 1, 9, 10};    // addi
            6'b000100: return '{0, 1, 8};        // beq
            6'b000010: return '{0, 1, 11};       // j
            default:   return '{0, 1};           // illegal
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(input int s);
        ctrl_t c = '0;
        case (s)
            0:  begin c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
            1:  c.alu_src_b = 2'b11;
            2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3:  c.iord = 1;
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; end
            5:  begin c.iord = 1; c.mem_write = 1; end
            6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_dst = 1; c.reg_write = 1; end
            8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1; end
            9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            10: c.reg_write = 1;
            11: begin c.pc_src = 2'b10; c.pc_write = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return seq_for(op).size() > 2;
    endfunction

    // Run one instruction starting in FETCH (#1 after an edge). zero_sel<0 means
    // random Zero each cycle; abort_at>=0 pulses reset during that step.
    task automatic run_instr(input logic [5:0] op, input int zero_sel, input int abort_at);
        seq_t  seq = seq_for(op);
        ctrl_t got, exp;
        for (int i = 0; i < seq.size(); i++) begin
            // Op only matters in DECODE/MEMADR; scramble it everywhere else.
            Op    = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
            Zero  = (zero_sel < 0) ? 1'($urandom) : zero_sel[0];
            reset = (i == abort_at);
            #1;
            exp = exp_ctrl(seq[i]);
            got = '{ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
                    RegDst, MemtoReg, RegWrite, PCWrite, Branch};
            check("state", 32'(State), 32'(seq[i]));
            check("outputs", 32'(got), 32'(exp));
            check("pcen", 32'(PCEn), 32'(exp.pc_write | (exp.branch & Zero)));
            check("illegal", 32'(IllegalOp), 32'(exp_illegal));
            check("excl", 32'($countones({RegWrite, MemWrite, IRWrite}) <= 1), 32'd1);
            @(posedge clk);
            #1;
            if (reset) begin
                reset       = 1'b0;
                exp_illegal = 1'b0;
                return;
            end
            if (seq[i] == 1 && !is_legal(op)) exp_illegal = 1'b1;
        end
    endtask

    initial begin
        seq_t s;
        logic [5:0] op;
        logic [5:0] legal_ops [6];
        legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011; legal_ops[2] = 6'b000000;
        legal_ops[3] = 6'b000100; legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;

        reset = 1'b1; Op = 6'b100011; Zero = 1'b1; exp_illegal = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_state", 32'(State), 32'd0);
        check("rst_pcen", 32'(PCEn), 32'd1);

        // Directed walk of each class, then the boundary cases.
        run_instr(6'b100011, -1, -1);
        run_instr(6'b101011, -1, -1);
        run_instr(6'b000000, -1, -1);
        run_instr(6'b000100,  1, -1);
        run_instr(6'b000100,  0, -1);
        run_instr(6'b000010, -1, -1);
        run_instr(6'b111111, -1, -1);
        run_instr(6'b001000, -1, -1);  // IllegalOp must stay set
        run_instr(6'b100011, -1,  3);  // reset in MEMRD clears state and flag
        check("abort_state", 32'(State), 32'd0);
        check("abort_illegal", 32'(IllegalOp), 32'd0);

        // Random instruction stream with occasional mid-instruction resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 5)];
            s = seq_for(op);
            if ($urandom_range(0, 15) == 0)
                run_instr(op, -1, int'($urandom_range(0, s.size() - 1)));
            else
                run_instr(op, -1, -1);
        end
        check("end_state", 32'(State), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
